// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution unit: condition mode
// encodings, FSM states and the flush counter width.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQZ = 3'd1;
  localparam logic [2:0] BR_BNEZ = 3'd2;
  localparam logic [2:0] BR_BLTZ = 3'd3;
  localparam logic [2:0] BR_BGEZ = 3'd4;
  localparam logic [2:0] BR_BGTZ = 3'd5;
  localparam logic [2:0] BR_BLEZ = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: zero-detect and sign bit of a
// two's-complement operand feed an 8:1 select on the condition mode.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] operand,
  input  logic [2:0]        br_mode,
  output logic              taken
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (operand == '0);
  assign is_neg  = operand[DATA_W-1];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    taken = 1'b0;
    case (br_mode)
      BR_NONE: taken = 1'b0;
      BR_BEQZ: taken = is_zero;
      BR_BNEZ: taken = ~is_zero;
      BR_BLTZ: taken = is_neg;
      BR_BGEZ: taken = ~is_neg;
      BR_BGTZ: taken = ~is_neg & ~is_zero;
      BR_BLEZ: taken = is_neg | is_zero;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: registers the taken decision and target, runs a
// stall-aware flush of FLUSH_CYCLES cycles and keeps saturating statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [2:0]        br_mode,
  input  logic [DATA_W-1:0] operand,
  input  logic [ADDR_W-1:0] target,
  input  logic              stall,
  output logic              branch_en,
  output logic [ADDR_W-1:0] branch_target,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   branch_en_q, branch_en_d;
  logic [ADDR_W-1:0]      target_q, target_d;
  logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]       taken_cnt_q, taken_cnt_d;

  logic cond_taken;
  logic accept;
  logic take;

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond_eval (
    .operand (operand),
    .br_mode (br_mode),
    .taken   (cond_taken)
  );

  // Instructions arriving while flushing are shadow instructions and are dropped.
  assign accept = valid_in & ~stall & (state_q == ST_IDLE);
  assign take   = accept & cond_taken;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    branch_en_d  = take;
    target_d     = target_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    if (take) begin
      target_d = target;
    end

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
            state_d     = ST_IDLE;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = '0;
      end
    endcase

    // Statistics saturate at all-ones rather than wrapping.
    if (accept && (br_mode != BR_NONE) && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (take && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      branch_en_q  <= 1'b0;
      target_q     <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      branch_en_q  <= branch_en_d;
      target_q     <= target_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_en     = branch_en_q;
  assign branch_target = target_q;
  assign flush         = (state_q == ST_FLUSH);
  assign busy          = (state_q == ST_FLUSH);
  assign branch_cnt    = branch_cnt_q;
  assign taken_cnt     = taken_cnt_q;

endmodule
